image_frame_buffer: RTL

Ping-pong frame buffer that sits directly upstream of the LCD timing stage. It accepts a 28x28 8-bit grayscale image as a valid/ready pixel stream from the CNN input loader or UART receiver. It serves the LCD's registered read address with one-cycle-latency read data. Bank swaps happen only on a rising VSYNC edge, so the panel never shows a half-written frame.

---
 rtl/image_frame_buffer_pkg.sv | 22 ++
 rtl/image_frame_buffer_if.sv | 26 ++
 rtl/image_frame_buffer_fb_bank_ram.sv | 31 +++
 rtl/image_frame_buffer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/image_frame_buffer_pkg.sv
// Shared definitions for the image frame buffer, the LCD timing stage and the
// CNN input loader: image geometry, pixel/address types and write FSM states.
package img_pkg;
    localparam int IMG_W      = 28;
    localparam int IMG_H      = 28;
    localparam int PIX_W      = 8;
    localparam int IMG_PIXELS = IMG_W * IMG_H;
    // Must satisfy 2**ADDR_W >= IMG_PIXELS.
    localparam int ADDR_W     = 10;

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL
    } fb_state_t;

    // Address of the final pixel of a frame.
    localparam addr_t LAST_ADDR = addr_t'(IMG_PIXELS - 1);
endpackage

// File: rtl/image_frame_buffer_if.sv
// Pixel stream, LCD read port and status bundle of the image frame buffer.
// master = pixel source / LCD side, slave = the frame buffer.
interface image_frame_buffer_if;
    import img_pkg::*;

    logic  pix_valid;
    logic  pix_ready;
    pix_t  pix_data;
    logic  pix_sof;
    logic  lcd_vsync;
    addr_t rd_addr;
    pix_t  rd_data;
    logic  disp_valid;
    logic  frame_swapped;
    logic  sof_err;

    modport master (
        output pix_valid, pix_data, pix_sof, lcd_vsync, rd_addr,
        input  pix_ready, rd_data, disp_valid, frame_swapped, sof_err
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof, lcd_vsync, rd_addr,
        output pix_ready, rd_data, disp_valid, frame_swapped, sof_err
    );
endinterface

// File: rtl/image_frame_buffer_fb_bank_ram.sv
// One frame bank: simple dual-port RAM, one write port and one registered read
// port. No reset on the array or read register so it maps onto block RAM.
module fb_bank_ram #(
    parameter int DEPTH = 784,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] rd_data_reg;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; out-of-range addresses are masked by the caller.
    always_ff @(posedge clk) begin
        rd_data_reg <= mem[rd_addr];
    end

    assign rd_data = rd_data_reg;
endmodule

// File: rtl/image_frame_buffer.sv
// Ping-pong frame buffer in front of the LCD timing stage. One bank is filled
// from the pixel stream while the other is displayed; banks swap only on a
// rising LCD vsync edge once a full frame has been written.
module image_frame_buffer
    import img_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    image_frame_buffer_if.slave  bus
);
    fb_state_t state_reg;
    addr_t     wr_cnt_reg;
    logic      wr_sel_reg;
    logic      vs_q_reg;
    logic      pix_ready_reg;
    logic      disp_valid_reg;
    logic      frame_swapped_reg;
    logic      sof_err_reg;
    logic      rd_sel_reg;
    logic      rd_ok_reg;

    logic      beat;
    logic      vs_rise;
    logic      wr_en;
    addr_t     wr_addr;
    pix_t      bank_rd_data [2];

    assign beat    = bus.pix_valid && pix_ready_reg;
    assign vs_rise = bus.lcd_vsync && !vs_q_reg;

    // pix_ready is low in FULL, so any beat is either a frame start or a FILL write.
    always_comb begin
        wr_en   = beat && (bus.pix_sof || (state_reg == FILL));
        wr_addr = bus.pix_sof ? '0 : wr_cnt_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            fb_bank_ram #(
                .DEPTH (IMG_PIXELS),
                .AW    (ADDR_W),
                .DW    (PIX_W)
            ) u_ram (
                .clk     (clk),
                .we      (wr_en && (wr_sel_reg == 1'(gi))),
                .wr_addr (wr_addr),
                .wr_data (bus.pix_data),
                .rd_addr (bus.rd_addr),
                .rd_data (bank_rd_data[gi])
            );
        end
    endgenerate

    // Write FSM, vsync edge detect and bank swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            wr_cnt_reg        <= '0;
            wr_sel_reg        <= 1'b0;
            vs_q_reg          <= 1'b0;
            pix_ready_reg     <= 1'b0;
            disp_valid_reg    <= 1'b0;
            frame_swapped_reg <= 1'b0;
            sof_err_reg       <= 1'b0;
        end else begin
            vs_q_reg          <= bus.lcd_vsync;
            frame_swapped_reg <= 1'b0;
            sof_err_reg       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    pix_ready_reg <= 1'b1;
                    if (beat && bus.pix_sof) begin
                        wr_cnt_reg <= addr_t'(1);
                        state_reg  <= FILL;
                    end
                end
                FILL: begin
                    if (beat) begin
                        if (bus.pix_sof) begin
                            // Restart: this beat already landed at address 0.
                            wr_cnt_reg  <= addr_t'(1);
                            sof_err_reg <= 1'b1;
                        end else if (wr_cnt_reg == LAST_ADDR) begin
                            wr_cnt_reg    <= '0;
                            pix_ready_reg <= 1'b0;
                            state_reg     <= FULL;
                        end else begin
                            wr_cnt_reg <= wr_cnt_reg + addr_t'(1);
                        end
                    end
                end
                FULL: begin
                    // Only an edge seen while already FULL swaps, so an edge
                    // coinciding with the last beat waits for the next one.
                    if (vs_rise) begin
                        wr_sel_reg        <= ~wr_sel_reg;
                        disp_valid_reg    <= 1'b1;
                        frame_swapped_reg <= 1'b1;
                        pix_ready_reg     <= 1'b1;
                        state_reg         <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Read qualifiers captured alongside the RAM read, so a read issued in the
    // swap cycle still returns the old display bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel_reg <= 1'b0;
            rd_ok_reg  <= 1'b0;
        end else begin
            rd_sel_reg <= ~wr_sel_reg;
            rd_ok_reg  <= disp_valid_reg && (bus.rd_addr <= LAST_ADDR);
        end
    end

    assign bus.rd_data       = rd_ok_reg ? bank_rd_data[rd_sel_reg] : '0;
    assign bus.pix_ready     = pix_ready_reg;
    assign bus.disp_valid    = disp_valid_reg;
    assign bus.frame_swapped = frame_swapped_reg;
    assign bus.sof_err       = sof_err_reg;
endmodule
